pixel_op_sequencer: RTL and testbench

//  Frame-level controller for the imageProcessing datapath. On start it streams every pixel of a source

---
 rtl/pixel_op_sequencer_if.sv | 33 +++
 rtl/pixel_op_sequencer.sv | 127 ++++++++++++
 tb/tb_pixel_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_op_sequencer_if.sv
// pixel_op_sequencer_if: control, source-read, datapath and destination-write bus of the frame sequencer
interface pixel_op_sequencer_if #(parameter int ADDR_W = 17);
  logic              start;
  logic              abort;
  logic [3:0]        op_mask;
  logic [7:0]        value_in;
  logic [7:0]        threshold_in;
  logic              busy;
  logic              done;
  logic [1:0]        cur_op;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_rdata;
  logic [7:0]        dp_inbyte;
  logic [1:0]        dp_select;
  logic [7:0]        dp_value;
  logic [7:0]        dp_threshold;
  logic [7:0]        dp_outbyte;
  logic              dst_wr_en;
  logic [1:0]        dst_op;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_wdata;
  modport master (
    input  start, abort, op_mask, value_in, threshold_in, src_rdata, dp_outbyte,
    output busy, done, cur_op, src_rd_en, src_addr, dp_inbyte, dp_select, dp_value, dp_threshold,
           dst_wr_en, dst_op, dst_addr, dst_wdata
  );
  modport slave (
    output start, abort, op_mask, value_in, threshold_in, src_rdata, dp_outbyte,
    input  busy, done, cur_op, src_rd_en, src_addr, dp_inbyte, dp_select, dp_value, dp_threshold,
           dst_wr_en, dst_op, dst_addr, dst_wdata
  );
endinterface

// File: rtl/pixel_op_sequencer.sv
// pixel_op_sequencer: streams a source frame through the pixel datapath once per enabled op
module pixel_op_sequencer #(
  parameter int NUM_PIXELS = 98304,
  parameter int ADDR_W     = 17,
  parameter int RD_LAT     = 1,
  parameter int DP_LAT     = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pixel_op_sequencer_if.master bus
);
  localparam int LAT = RD_LAT + DP_LAT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t            r_state;
  logic [3:0]        r_mask;
  logic [LAT-1:0]    r_vld;
  logic [ADDR_W-1:0] r_adr [LAT];
  logic [1:0]        r_op;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_inbyte;
  logic [7:0]        r_value;
  logic [7:0]        r_thr;
  logic              r_wr;
  logic [1:0]        r_dop;
  logic [ADDR_W-1:0] r_dadr;
  logic [7:0]        r_wdata;
  logic [3:0]        w_rem;
  logic [1:0]        w_next;
  logic [1:0]        w_first;
  function automatic logic [1:0] f_low(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  // ops still pending above the one currently streaming
  assign w_rem   = r_mask & (4'b1110 << r_op);
  assign w_next  = f_low(w_rem);
  assign w_first = f_low(bus.op_mask);
  // stage 0 of the valid/address pipe is the read strobe itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_vld    <= '0;
      for (int k = 0; k < LAT; k++) r_adr[k] <= '0;
      r_op     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_inbyte <= '0;
      r_value  <= '0;
      r_thr    <= '0;
      r_wr     <= 1'b0;
      r_dop    <= '0;
      r_dadr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_vld[LAT-1:1] <= r_vld[LAT-2:0];
      for (int k = 1; k < LAT; k++) r_adr[k] <= r_adr[k-1];
      if (r_vld[RD_LAT-1]) r_inbyte <= bus.src_rdata;
      r_wr <= r_vld[LAT-1];
      if (r_vld[LAT-1]) begin
        r_dadr  <= r_adr[LAT-1];
        r_wdata <= bus.dp_outbyte;
        r_dop   <= r_op;
      end
      case (r_state)
        IDLE: if (bus.start) begin
          r_mask  <= bus.op_mask;
          r_value <= bus.value_in;
          r_thr   <= bus.threshold_in;
          r_op    <= w_first;
          if (|bus.op_mask) begin
            r_state  <= STREAM;
            r_busy   <= 1'b1;
            r_vld[0] <= 1'b1;
            r_adr[0] <= '0;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        STREAM: if (r_adr[0] == LAST) begin
          r_state  <= DRAIN;
          r_vld[0] <= 1'b0;
        end else r_adr[0] <= r_adr[0] + 1'b1;
        // select only moves once every in-flight pixel has left the pipe
        DRAIN: if (~|r_vld) begin
          if (|w_rem) begin
            r_state  <= STREAM;
            r_op     <= w_next;
            r_vld[0] <= 1'b1;
            r_adr[0] <= '0;
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (bus.abort && r_state != IDLE) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_vld   <= '0;
        r_wr    <= 1'b0;
      end
    end
  end
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.cur_op       = r_op;
  assign bus.src_rd_en    = r_vld[0];
  assign bus.src_addr     = r_adr[0];
  assign bus.dp_inbyte    = r_inbyte;
  assign bus.dp_select    = r_op;
  assign bus.dp_value     = r_value;
  assign bus.dp_threshold = r_thr;
  assign bus.dst_wr_en    = r_wr;
  assign bus.dst_op       = r_dop;
  assign bus.dst_addr     = r_dadr;
  assign bus.dst_wdata    = r_wdata;
endmodule

// File: tb/tb_pixel_op_sequencer.sv
// tb_pixel_op_sequencer: scoreboard bench for the frame sequencer with a 16-pixel frame
module tb_pixel_op_sequencer;
  localparam int N  = 16;
  localparam int AW = 4;
  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  pixel_op_sequencer_if #(.ADDR_W(AW)) bus ();
  pixel_op_sequencer #(.NUM_PIXELS(N), .ADDR_W(AW), .RD_LAT(1), .DP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  function automatic logic [7:0] px(input logic [1:0] op, input logic [7:0] p, input logic [7:0] v,
                                    input logic [7:0] t);
    logic [8:0] s;
    s = {1'b0, p} + {1'b0, v};
    case (op)
      2'd0:    return s[8] ? 8'hFF : s[7:0];
      2'd1:    return (p < v) ? 8'h00 : p - v;
      2'd2:    return (p >= t) ? 8'hFF : 8'h00;
      default: return ~p;
    endcase
  endfunction
  // source memory (src[i]=8*i, one-cycle latency) and datapath stand-in
  assign bus.src_rdata  = 8'({bus.src_addr, 3'b000});
  assign bus.dp_outbyte = px(bus.dp_select, bus.dp_inbyte, bus.dp_value, bus.dp_threshold);
  exp_t          q[$];
  int            vec = 0, err = 0;
  int            n_rd, n_wr, n_done, cyc, first_rd, first_wr;
  logic [AW-1:0] rd_exp;
  logic [1:0]    prev_sel;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (n_rd != n_wr) begin
        vec++;
        if (bus.dp_select !== prev_sel) begin
          err++;
          $display("FAIL sel_stable: dp_select %0d moved from %0d with pixels in flight", bus.dp_select, prev_sel);
        end
      end
      prev_sel = bus.dp_select;
      if (bus.src_rd_en) begin
        vec++;
        if (bus.src_addr !== rd_exp) begin
          err++;
          $display("FAIL rd_addr: got %0d expected %0d", bus.src_addr, rd_exp);
        end
        if (n_rd == 0) first_rd = cyc;
        n_rd++;
        rd_exp = (rd_exp == AW'(N - 1)) ? '0 : rd_exp + 1'b1;
      end
      if (bus.dst_wr_en) begin
        vec++;
        if (n_wr == 0) first_wr = cyc;
        n_wr++;
        if (q.size() == 0) begin
          err++;
          $display("FAIL wr_unexpected: op %0d addr %0d data %h with empty scoreboard", bus.dst_op, bus.dst_addr, bus.dst_wdata);
        end else begin
          e = q.pop_front();
          if ({bus.dst_op, bus.dst_addr, bus.dst_wdata} !== e) begin
            err++;
            $display("FAIL wr_data: got op %0d addr %0d data %h expected op %0d addr %0d data %h",
                     bus.dst_op, bus.dst_addr, bus.dst_wdata, e.op, e.addr, e.data);
          end
        end
      end
      if (bus.done) n_done++;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic start_job(input logic [3:0] mask, input logic [7:0] v, input logic [7:0] t, input int limit,
                           input bit hold);
    int pushed = 0;
    tick(1);
    for (int o = 0; o < 4; o++)
      if (mask[o])
        for (int a = 0; a < N; a++)
          if (pushed < limit) begin
            q.push_back({2'(o), AW'(a), px(2'(o), 8'(a * 8), v, t)});
            pushed++;
          end
    n_rd = 0; n_wr = 0; n_done = 0; rd_exp = '0;
    bus.op_mask = mask; bus.value_in = v; bus.threshold_in = t; bus.start = 1'b1;
    tick(1);
    if (!hold) bus.start = 1'b0;
  endtask
  task automatic wait_done(output int busy_cnt, output int waited, output bit ok);
    busy_cnt = 0; waited = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        ok = 1'b1;
        waited = i;
        break;
      end
      tick(1);
    end
  endtask
  task automatic test_reset;
    tick(3);
    vec++;
    if ({bus.busy, bus.done, bus.cur_op, bus.src_rd_en, bus.src_addr, bus.dp_inbyte, bus.dp_select, bus.dp_value,
         bus.dp_threshold, bus.dst_wr_en, bus.dst_op, bus.dst_addr, bus.dst_wdata} !== '0) begin
      err++;
      $display("FAIL reset_outputs: busy %b done %b src_rd_en %b dst_wr_en %b src_addr %0d required all zero",
               bus.busy, bus.done, bus.src_rd_en, bus.dst_wr_en, bus.src_addr);
    end
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic test_single;
    int bc, w; bit ok;
    start_job(4'b0001, 8'h3C, 8'hA0, 1000, 1'b0);
    wait_done(bc, w, ok);
    tick(3);
    vec++;
    if (!ok || bc != 18) begin
      err++;
      $display("FAIL single_busy: done seen %0d busy cycles %0d required 1 and 18", ok, bc);
    end
    vec++;
    if (n_wr != 16 || n_rd != 16 || n_done != 1 || q.size() != 0) begin
      err++;
      $display("FAIL single_counts: reads %0d writes %0d dones %0d left %0d required 16 16 1 0", n_rd, n_wr, n_done, q.size());
    end
    vec++;
    if (first_wr - first_rd != 2) begin
      err++;
      $display("FAIL single_latency: got %0d cycles required 2", first_wr - first_rd);
    end
  endtask
  task automatic test_all_ops;
    int bc, w; bit ok;
    start_job(4'b1111, 8'h3C, 8'hA0, 1000, 1'b0);
    wait_done(bc, w, ok);
    tick(3);
    vec++;
    if (!ok || bc != 72) begin
      err++;
      $display("FAIL all_busy: done seen %0d busy cycles %0d required 1 and 72", ok, bc);
    end
    vec++;
    if (n_wr != 64 || n_done != 1 || q.size() != 0) begin
      err++;
      $display("FAIL all_counts: writes %0d dones %0d left %0d required 64 1 0", n_wr, n_done, q.size());
    end
  endtask
  task automatic test_empty_mask;
    int bc, w; bit ok;
    start_job(4'b0000, 8'h10, 8'h20, 1000, 1'b0);
    wait_done(bc, w, ok);
    tick(3);
    vec++;
    if (!ok || w != 0 || bc != 0) begin
      err++;
      $display("FAIL empty_done: done seen %0d after %0d cycles busy %0d required 1 0 0", ok, w, bc);
    end
    vec++;
    if (n_rd != 0 || n_wr != 0 || n_done != 1 || bus.done !== 1'b0) begin
      err++;
      $display("FAIL empty_counts: reads %0d writes %0d dones %0d required 0 0 1", n_rd, n_wr, n_done);
    end
  endtask
  task automatic test_abort;
    int bc, w; bit ok, hit;
    hit = 1'b0;
    start_job(4'b0101, 8'h3C, 8'hA0, 6, 1'b0);
    for (int i = 0; i < 40 && !hit; i++) begin
      if (bus.src_rd_en && bus.src_addr == AW'(7)) hit = 1'b1;
      else tick(1);
    end
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    vec++;
    if (!hit || bus.busy !== 1'b0 || bus.src_rd_en !== 1'b0) begin
      err++;
      $display("FAIL abort_idle: reached pixel 7 %0d busy %b src_rd_en %b required 1 0 0", hit, bus.busy, bus.src_rd_en);
    end
    tick(10);
    vec++;
    if (n_wr != 6 || n_done != 0 || q.size() != 0) begin
      err++;
      $display("FAIL abort_counts: writes %0d dones %0d left %0d required 6 0 0", n_wr, n_done, q.size());
    end
    start_job(4'b0100, 8'h3C, 8'hA0, 1000, 1'b0);
    wait_done(bc, w, ok);
    tick(3);
    vec++;
    if (!ok || bc != 18 || n_wr != 16 || q.size() != 0) begin
      err++;
      $display("FAIL abort_restart: done %0d busy %0d writes %0d left %0d required 1 18 16 0", ok, bc, n_wr, q.size());
    end
  endtask
  task automatic test_start_held;
    int bc, w; bit ok;
    start_job(4'b0010, 8'h55, 8'h40, 1000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      bus.start = (i < 10) ? 1'b1 : i[0];
      tick(1);
    end
    bus.start = 1'b0;
    wait_done(bc, w, ok);
    tick(6);
    vec++;
    if (!ok || n_done != 1 || n_rd != 16 || n_wr != 16 || bus.busy !== 1'b0 || q.size() != 0) begin
      err++;
      $display("FAIL start_held: done %0d dones %0d reads %0d writes %0d busy %b required 1 1 16 16 0",
               ok, n_done, n_rd, n_wr, bus.busy);
    end
  endtask
  task automatic test_reset_mid;
    start_job(4'b0001, 8'h3C, 8'hA0, 1000, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.busy, bus.done, bus.cur_op, bus.src_rd_en, bus.src_addr, bus.dp_inbyte, bus.dp_select, bus.dp_value,
         bus.dp_threshold, bus.dst_wr_en, bus.dst_op, bus.dst_addr, bus.dst_wdata} !== '0) begin
      err++;
      $display("FAIL reset_mid: busy %b src_rd_en %b dst_wr_en %b src_addr %0d required all zero",
               bus.busy, bus.src_rd_en, bus.dst_wr_en, bus.src_addr);
    end
    tick(1);
    rst_n = 1'b1;
    q.delete();
    n_rd = 0; n_wr = 0; n_done = 0;
    tick(4);
    vec++;
    if (bus.busy !== 1'b0 || n_rd != 0 || n_wr != 0 || n_done != 0) begin
      err++;
      $display("FAIL reset_idle: busy %b reads %0d writes %0d dones %0d required 0 0 0 0", bus.busy, n_rd, n_wr, n_done);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.op_mask = '0; bus.value_in = '0; bus.threshold_in = '0;
    n_rd = 0; n_wr = 0; n_done = 0; cyc = 0; first_rd = 0; first_wr = 0; rd_exp = '0; prev_sel = '0;
    test_reset;
    test_single;
    test_all_ops;
    test_empty_mask;
    test_abort;
    test_start_held;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
